// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM transaction sequencer and the I2C EEPROM
// controller: FSM states, error codes, control/status bit positions, op codes.
package eeprom_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    CLEAR   = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ALIGN   = 2'd3;

  // Controller control word fields
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 3;
  localparam int CTRL_RATE_LSB = 4;
  localparam int CTRL_RATE_MSB = 6;
  localparam int CTRL_CLR      = 7;

  // Controller status word fields
  localparam int ST_FINISH    = 1;
  localparam int ST_STATE_LSB = 2;
  localparam int ST_STATE_MSB = 9;
  localparam int ST_SMEN      = 10;

  localparam logic [2:0] OP_WREG = 3'd0;
  localparam logic [2:0] OP_RREG = 3'd1;

  // Counter load value for a wait of 'clks' cycles; the counter reaches zero
  // after clks-1 decrements, and 0 collapses to a single-cycle pass-through.
  function automatic logic [31:0] cnt_load(input int unsigned clks);
    return (clks == 0) ? 32'd0 : 32'(clks - 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that stops at zero and flags when it is there.
module seq_down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Load takes priority over counting; counting saturates at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/eeprom_txn_sequencer.sv
// Converts one CPU 4-byte read/write request into the I2C EEPROM controller
// control-word handshake, including finish-clear and the EEPROM write-cycle wait.
module eeprom_txn_sequencer
  import eeprom_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR      = 7'h50,
  parameter logic [2:0]  CLK_RATE      = 3'd7,
  parameter int unsigned WR_CYCLE_CLKS = 500000,
  parameter int unsigned TIMEOUT_CLKS  = 2000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_ctrl,
  output logic [6:0]  o_dev_addr,
  output logic [15:0] o_reg_addr,
  output logic [31:0] o_w_data,
  input  logic [31:0] i_status,
  input  logic [7:0]  i_rd_data0,
  input  logic [7:0]  i_rd_data1,
  input  logic [7:0]  i_rd_data2,
  input  logic [7:0]  i_rd_data3
);

  localparam logic [31:0] TO_LOAD = cnt_load(TIMEOUT_CLKS);
  localparam logic [31:0] WR_LOAD = cnt_load(WR_CYCLE_CLKS);

  seq_state_t                r_state;
  seq_state_t                w_next;
  logic [ST_SMEN:ST_FINISH]  r_st_q;
  logic                      r_busy;
  logic                      r_done;
  logic [1:0]                r_err;
  logic [31:0]               r_rdata;
  logic                      r_rw;
  logic [15:0]               r_reg_addr;
  logic [31:0]               r_w_data;
  logic [31:0]               w_ctrl;
  logic                      w_accept;
  logic                      w_misaligned;
  logic                      w_finish;
  logic                      w_ctl_idle;
  logic                      w_wr_ok;
  logic                      w_to_zero;
  logic                      w_wr_zero;
  logic                      w_unused_status;

  // Status bits the sequencer never looks at
  assign w_unused_status = ^{i_status[31:ST_SMEN+1], i_status[ST_FINISH-1:0]};

  // A request landing on the o_done cycle is dropped; the CPU re-issues later
  assign w_accept     = (r_state == IDLE) && i_req && !r_busy && !r_done;
  assign w_misaligned = (i_addr[1:0] != 2'b00);
  assign w_finish     = r_st_q[ST_FINISH];
  assign w_ctl_idle   = !r_st_q[ST_SMEN] && (r_st_q[ST_STATE_MSB:ST_STATE_LSB] == 8'd0);
  assign w_wr_ok      = !r_rw && (r_err == ERR_OK);

  seq_down_counter #(.WIDTH(32)) u_timeout_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept && !w_misaligned),
    .i_value (TO_LOAD),
    .i_en    ((r_state == LAUNCH) || (r_state == RUN)),
    .o_zero  (w_to_zero)
  );

  seq_down_counter #(.WIDTH(32)) u_wrcycle_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  ((r_state == CLEAR) && (w_next == WR_WAIT)),
    .i_value (WR_LOAD),
    .i_en    (r_state == WR_WAIT),
    .o_zero  (w_wr_zero)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; progress on status wins over a same-cycle timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_misaligned ? DONE : LAUNCH;
      LAUNCH:  if (r_st_q[ST_SMEN]) w_next = RUN;
               else if (w_to_zero) w_next = DONE;
      RUN:     if (w_finish || w_ctl_idle) w_next = CLEAR;
               else if (w_to_zero) w_next = DONE;
      CLEAR:   if (!w_finish) w_next = w_wr_ok ? WR_WAIT : DONE;
      WR_WAIT: if (w_wr_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Control word decode; clear is only driven while finish is still seen
  always_comb begin
    w_ctrl = '0;
    if ((r_state == LAUNCH) || (r_state == RUN) || (r_state == CLEAR)) begin
      w_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] = r_rw ? OP_RREG : OP_WREG;
      w_ctrl[CTRL_RATE_MSB:CTRL_RATE_LSB] = CLK_RATE;
    end
    if (r_state == LAUNCH) w_ctrl[CTRL_EN]  = 1'b1;
    if (r_state == CLEAR)  w_ctrl[CTRL_CLR] = w_finish;
  end

  // Request latch, status sampling, result and handshake registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_st_q     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_OK;
      r_rdata    <= '0;
      r_rw       <= 1'b0;
      r_reg_addr <= '0;
      r_w_data   <= '0;
    end else begin
      r_st_q <= i_status[ST_SMEN:ST_FINISH];
      r_done <= (r_state == DONE);
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_rw       <= i_rw;
        r_reg_addr <= i_addr;
        r_w_data   <= i_wdata;
        r_err      <= w_misaligned ? ERR_ALIGN : ERR_OK;
      end else if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
      if ((r_state == RUN) && w_finish && r_rw)
        r_rdata <= {i_rd_data0, i_rd_data1, i_rd_data2, i_rd_data3};
      if ((r_state == RUN) && !w_finish && w_ctl_idle)
        r_err <= ERR_NACK;
      if (((r_state == LAUNCH) || (r_state == RUN)) && (w_next == DONE))
        r_err <= ERR_TIMEOUT;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_ctrl     = w_ctrl;
  assign o_dev_addr = DEV_ADDR;
  assign o_reg_addr = r_reg_addr;
  assign o_w_data   = r_w_data;

endmodule

// File: tb/tb_eeprom_txn_sequencer.sv
// Scoreboard bench for eeprom_txn_sequencer with a status-level model of the
// I2C EEPROM controller and a byte-addressed EEPROM memory behind it.
module tb_eeprom_txn_sequencer;

  localparam int unsigned WR_CLKS = 200;
  localparam int unsigned TO_CLKS = 1000;
  localparam int          LAT     = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        o_busy, o_done;
  logic [1:0]  o_err;
  logic [31:0] o_rdata, o_ctrl, o_w_data, status;
  logic [6:0]  o_dev_addr;
  logic [15:0] o_reg_addr;

  // Controller model state
  logic        m_en, m_fin, m_ack;
  logic [7:0]  m_state;
  int          m_cnt;
  logic [2:0]  m_op;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  logic [7:0]  m_rd0, m_rd1, m_rd2, m_rd3;
  logic [7:0]  mem [0:65535];
  logic [6:0]  m_model_addr = 7'h50;
  logic        m_hang = 1'b0;
  logic        m_abort = 1'b0;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int clr_cnt = 0;

  always #5 clk = ~clk;

  assign status = {21'd0, m_en, m_state, m_fin, 1'b0};

  eeprom_txn_sequencer #(
    .DEV_ADDR(7'h50), .CLK_RATE(3'd7), .WR_CYCLE_CLKS(WR_CLKS), .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rw(rw), .i_addr(addr), .i_wdata(wdata),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_ctrl(o_ctrl), .o_dev_addr(o_dev_addr), .o_reg_addr(o_reg_addr), .o_w_data(o_w_data),
    .i_status(status), .i_rd_data0(m_rd0), .i_rd_data1(m_rd1), .i_rd_data2(m_rd2),
    .i_rd_data3(m_rd3)
  );

  // Controller model: enable starts a LAT-cycle transfer, then finish (ACK) or
  // a silent return to idle (NACK); finish clears when the clear bit is seen
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en <= 1'b0; m_fin <= 1'b0; m_state <= '0; m_cnt <= 0; m_ack <= 1'b0;
      m_rd0 <= '0; m_rd1 <= '0; m_rd2 <= '0; m_rd3 <= '0;
    end else if (m_abort) begin
      m_en <= 1'b0; m_fin <= 1'b0; m_state <= '0;
    end else begin
      if (m_fin && o_ctrl[7]) m_fin <= 1'b0;
      if (!m_en && !m_fin && o_ctrl[0]) begin
        m_en <= 1'b1; m_state <= 8'h01; m_cnt <= LAT;
        m_op <= o_ctrl[3:1]; m_addr <= o_reg_addr; m_wd <= o_w_data;
        m_ack <= (o_dev_addr == m_model_addr);
      end else if (m_en && !m_hang) begin
        if (m_cnt > 0) m_cnt <= m_cnt - 1;
        else begin
          m_en <= 1'b0; m_state <= '0;
          if (m_ack) begin
            m_fin <= 1'b1;
            if (m_op == 3'd1) begin
              m_rd0 <= mem[m_addr];          m_rd1 <= mem[m_addr + 16'd1];
              m_rd2 <= mem[m_addr + 16'd2];  m_rd3 <= mem[m_addr + 16'd3];
            end else begin
              mem[m_addr]         <= m_wd[31:24]; mem[m_addr + 16'd1] <= m_wd[23:16];
              mem[m_addr + 16'd2] <= m_wd[15:8];  mem[m_addr + 16'd3] <= m_wd[7:0];
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pops one expectation per o_done pulse
  always @(negedge clk) begin
    exp_t e;
    if (o_ctrl[7]) clr_cnt++;
    if (o_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected_done: got o_done with err %0d, expected no completion", o_err);
      end else begin
        e = sb.pop_front();
        check("sb_err", 32'(o_err), 32'(e.err));
        check("sb_rdata", o_rdata, e.rdata);
        check("sb_busy_at_done", 32'(o_busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic r, input logic [15:0] a, input logic [31:0] d);
    rw = r; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles, output int fin_fall);
    int   start;
    logic prev_fin;
    start = done_cnt; cycles = 0; fin_fall = -1; prev_fin = status[1];
    while (done_cnt == start && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (prev_fin && !status[1]) fin_fall = cycles;
      prev_fin = status[1];
    end
    n_checks++;
    if (done_cnt == start) begin
      n_fail++;
      $display("FAIL %s_wait: got no o_done in %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_ctrl"}, o_ctrl, 32'd0);
    check({tag, "_reg_addr"}, 32'(o_reg_addr), 32'd0);
    check({tag, "_w_data"}, o_w_data, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ff, snap;
    logic [31:0] exp_rdata;
    exp_rdata = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    check("dev_addr", 32'(o_dev_addr), 32'h50);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write DEADBEEF at 0x0040
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b0, 16'h0040, 32'hDEADBEEF);
    check("wr_busy_rise", 32'(o_busy), 32'd1);
    check("wr_reg_addr", 32'(o_reg_addr), 32'h0040);
    check("wr_w_data", o_w_data, 32'hDEADBEEF);
    wait_done("wr1", 2000, cyc, ff);
    check_range("wr_cycle_wait", cyc - ff, int'(WR_CLKS), int'(WR_CLKS) + 8);
    check("wr_bytes", {mem[16'h0040], mem[16'h0041], mem[16'h0042], mem[16'h0043]}, 32'hDEADBEEF);

    // Write 11 22 33 44, then read it back
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b0, 16'h0040, 32'h11223344);
    wait_done("wr2", 2000, cyc, ff);
    exp_rdata = 32'h11223344;
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b1, 16'h0040, 32'h0);
    wait_done("rd1", 2000, cyc, ff);

    // Device at a different address: NACK on write and read
    m_model_addr = 7'h51;
    snap = clr_cnt;
    sb.push_back('{err: 2'd1, rdata: exp_rdata});
    issue(1'b0, 16'h0044, 32'hA5A5A5A5);
    wait_done("nack_wr", 2000, cyc, ff);
    check_range("nack_wr_no_wrwait", cyc, 1, int'(WR_CLKS) - 1);
    check("nack_wr_no_clear", 32'(clr_cnt - snap), 32'd0);
    sb.push_back('{err: 2'd1, rdata: exp_rdata});
    issue(1'b1, 16'h0040, 32'h0);
    wait_done("nack_rd", 2000, cyc, ff);
    m_model_addr = 7'h50;
    repeat (2) @(posedge clk);
    #1;

    // Misaligned: o_done two cycles after i_req, no controller activity
    sb.push_back('{err: 2'd3, rdata: exp_rdata});
    issue(1'b0, 16'h0041, 32'h12345678);
    check("mis_busy", 32'(o_busy), 32'd1);
    check("mis_done_early", 32'(o_done), 32'd0);
    check("mis_ctrl1", o_ctrl, 32'd0);
    @(posedge clk); #1;
    check("mis_done", 32'(o_done), 32'd1);
    check("mis_err", 32'(o_err), 32'd3);
    check("mis_ctrl2", o_ctrl, 32'd0);
    // A request on the o_done cycle is dropped
    rw = 1'b1; addr = 16'h0040; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("req_on_done_ignored", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Timeout: controller never finishes
    m_hang = 1'b1;
    sb.push_back('{err: 2'd2, rdata: exp_rdata});
    issue(1'b1, 16'h0048, 32'h0);
    wait_done("timeout", 3000, cyc, ff);
    check_range("timeout_latency", cyc, int'(TO_CLKS), int'(TO_CLKS) + 10);
    check("timeout_ctrl", o_ctrl, 32'd0);
    check("timeout_err_held", 32'(o_err), 32'd2);
    m_hang = 1'b0; m_abort = 1'b1;
    @(posedge clk); #1;
    m_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a transfer
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b0, 16'h004C, 32'hCAFEF00D);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_in_run", 32'(status[10]), 32'd1);
    snap = done_cnt;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_rdata = 32'd0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - snap), 32'd0);
    exp_rdata = 32'h11223344;
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b1, 16'h0040, 32'h0);
    wait_done("rd_after_rst", 2000, cyc, ff);

    // Repeated i_req while busy is ignored
    snap = done_cnt;
    sb.push_back('{err: 2'd0, rdata: exp_rdata});
    issue(1'b1, 16'h0040, 32'h0);
    rw = 1'b0; addr = 16'h0041; req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req = 1'b0;
    check("b2b_addr_kept", 32'(o_reg_addr), 32'h0040);
    wait_done("b2b", 2000, cyc, ff);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_single_done", 32'(done_cnt - snap), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
